// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command FIFO feeding a multi-cycle ALU through an IDLE/ISSUE/HOLD issue FSM
module alu_cmd_issue #(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic        alu_AS,
  output logic        alu_sub,
  output logic        alu_Shift,
  output logic        alu_shift_left,
  output logic        alu_bitwiseAND,
  output logic        alu_bitwiseOR,
  input  logic [31:0] alu_result,
  input  logic        alu_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_cout,
  output logic [2:0]  res_op,
  output logic        res_err,
  output logic [15:0] op_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
  state_t state;
  logic [66:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [2:0] op_q, cnt, head_op;
  logic [5:0] ctrl, dec;
  logic push, pop, legal;
  assign cmd_ready = count < (PW+1)'(FIFO_DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign pop = state == IDLE && count != '0;
  assign head_op = mem[rd_ptr][66:64];
  assign legal = op_q < 3'd6;
  // control order: AS, sub, Shift, shift_left, bitwiseAND, bitwiseOR
  assign dec = head_op == 3'd0 ? 6'b100000 :
               head_op == 3'd1 ? 6'b110000 :
               head_op == 3'd2 ? 6'b001000 :
               head_op == 3'd3 ? 6'b001100 :
               head_op == 3'd4 ? 6'b000010 :
               head_op == 3'd5 ? 6'b000001 : 6'b000000;
  assign {alu_AS, alu_sub, alu_Shift, alu_shift_left, alu_bitwiseAND, alu_bitwiseOR} = ctrl;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      state <= IDLE;
      cnt <= '0;
      ctrl <= '0;
      op_q <= '0;
      alu_A <= '0;
      alu_B <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_cout <= 1'b0;
      res_op <= '0;
      res_err <= 1'b0;
      op_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      case (state)
        IDLE:
          if (pop) begin
            {op_q, alu_A, alu_B} <= mem[rd_ptr];
            ctrl <= dec;
            cnt <= '0;
            state <= ISSUE;
          end
        ISSUE:
          if (cnt == 3'(ALU_LAT - 1)) begin
            res_data <= legal ? alu_result : 32'd0;
            res_cout <= legal && alu_cout;
            res_err <= !legal;
            res_op <= op_q;
            res_valid <= 1'b1;
            ctrl <= '0;
            state <= HOLD;
          end else cnt <= cnt + 3'd1;
        HOLD:
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count <= op_count + 16'd1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_cmd_issue.md
ALU_CMD_ISSUE -- requirements
Module: alu_cmd_issue

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter ALU_LAT, default 1, meaning cycles from ALU controls/operands becoming stable to alu_result being sampled (1..4).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  FIFO can accept a command.
REQ-007 cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 SHR, 011 SHL, 100 AND, 101 OR, 110/111 illegal.
REQ-008 cmd_a, cmd_b  in  32 each  operands.
REQ-009 alu_A, alu_B  out  32 each  operands driven to the ALU.
REQ-010 alu_AS, alu_sub, alu_Shift, alu_shift_left, alu_bitwiseAND, alu_bitwiseOR  out  1 each  ALU mode controls.
REQ-011 alu_result  in  32 and alu_cout  in  1  ALU outputs.
REQ-012 res_valid  out  1 / res_ready  in  1  result handshake.
REQ-013 res_data  out  32, res_cout  out  1, res_op  out  3, res_err  out  1  result payload.
REQ-014 op_count  out  16  number of results accepted downstream.

Function
REQ-015 A command SHALL be written into the FIFO on any cycle with cmd_valid && cmd_ready; cmd_ready = (FIFO count < FIFO_DEPTH).
REQ-016 Simultaneous FIFO push and pop SHALL leave count unchanged; pop when empty or push when full SHALL never occur; read/write pointers wrap modulo FIFO_DEPTH.
REQ-017 FSM states: IDLE, ISSUE, HOLD.
REQ-018 IDLE: if FIFO non-empty, pop head into an issue register and go to ISSUE next cycle; else stay.
REQ-019 ISSUE: drive alu_A/alu_B from the issue register and decoded controls for exactly ALU_LAT cycles (wait counter), then capture alu_result and alu_cout into res_data/res_cout on the last ISSUE cycle edge and go to HOLD.
REQ-020 Decode: ADD AS=1,sub=0; SUB AS=1,sub=1; SHR Shift=1,shift_left=0; SHL Shift=1,shift_left=1; AND bitwiseAND=1; OR bitwiseOR=1; every other control 0.
REQ-021 Illegal opcode: all controls 0, ISSUE lasts ALU_LAT cycles anyway, captured res_data=0, res_cout=0, res_err=1; legal ops give res_err=0.
REQ-022 In IDLE and HOLD all six ALU controls SHALL be 0 and alu_A/alu_B SHALL hold their last value.
REQ-023 HOLD: res_valid=1 with payload stable until res_ready=1; on that cycle op_count increments (wraps 0xFFFF->0), go to IDLE.
REQ-024 res_valid SHALL be 1 only in HOLD; a result is never dropped or duplicated.
REQ-025 Throughput with res_ready tied high: one result per ALU_LAT+2 cycles; command order is preserved.
REQ-026 FIFO accepts commands in every FSM state, including during HOLD backpressure.

Reset
REQ-027 On reset: FIFO empty (cmd_ready=1 next cycle), FSM IDLE, wait counter 0, all ALU controls 0, alu_A=alu_B=0, res_valid=0, res_data=0, res_cout=0, res_op=0, res_err=0, op_count=0.
REQ-028 Reset asserted mid-ISSUE or mid-HOLD SHALL discard the in-flight command and all queued commands without producing res_valid.

Verification
REQ-029 ADD 22+33, then SUB 100-50 (ALU_LAT=1, res_ready=1) -> results 55 then 50 in order, res_err=0, alu_AS=1 during each ISSUE, alu_sub=1 only for SUB, op_count=2.
REQ-030 Push 5 commands back-to-back with res_ready=0, FIFO_DEPTH=4 -> one enters ISSUE, 4 fill FIFO, cmd_ready=0 once 4 queued; res_valid held with stable payload; releasing res_ready drains all 5 in order.
REQ-031 Opcode 111 with A=0xFFFFFFFF -> all controls 0 during ISSUE, res_data=0, res_err=1, res_op=111.
REQ-032 SHL, AND, OR sequence -> exactly one of Shift+shift_left, bitwiseAND, bitwiseOR high in respective ISSUE windows; res_data equals alu_result sampled on last ISSUE cycle.
REQ-033 Assert reset for 1 cycle while in HOLD with 2 queued -> res_valid=0, cmd_ready=1, op_count=0 next cycle; no further results appear.
REQ-034 ALU_LAT=3 with a slow-model ALU -> ISSUE lasts 3 cycles, controls stable throughout, result captured from third cycle.
